// File: rtl/relogio_pkg.sv
// Shared types and constants for the clock front-panel control path.
// Holds the adjustment FSM state type, selector width, button indices
// and the digit-advance helper used by controle_ajuste.
package relogio_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        AJUSTE = 1'b1
    } estado_t;

    localparam int SELETOR_W          = 3;
    localparam int NUM_DIGITS_DEFAULT = 6;

    // Bit positions inside the raw botao[3:1] bus
    localparam int BOTAO_MODO = 1;
    localparam int BOTAO_INC  = 2;
    localparam int BOTAO_PROX = 3;

    // Next digit index, wrapping from the last digit back to 0
    function automatic logic [SELETOR_W-1:0] proximo_digito(
        input logic [SELETOR_W-1:0] atual,
        input int                   num_digitos
    );
        if (int'(atual) >= num_digitos - 1) begin
            return '0;
        end
        return atual + SELETOR_W'(1);
    endfunction

endpackage

// File: rtl/debounce_botao.sv
// One pushbutton input path: 2-FF synchronizer, polarity normalisation
// (pressed = 1), debounce counter, accepted level and a one-cycle press
// event on each accepted released->pressed transition.
module debounce_botao #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int BOTAO_ATIVO_BAIXO = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic bruto,
    output logic nivel,
    output logic evento
);

    localparam int CONT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(DEBOUNCE_CYCLES - 1);
    // Raw level of a released button, so reset never fakes a press
    localparam logic SOLTO_BRUTO = (BOTAO_ATIVO_BAIXO != 0);

    logic              sinc1;
    logic              sinc2;
    logic              pressionado;
    logic [CONT_W-1:0] cont;

    // Two-stage synchronizer on the asynchronous button line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sinc1 <= SOLTO_BRUTO;
            sinc2 <= SOLTO_BRUTO;
        end else begin
            sinc1 <= bruto;
            sinc2 <= sinc1;
        end
    end

    assign pressionado = (BOTAO_ATIVO_BAIXO != 0) ? ~sinc2 : sinc2;

    // Accept a new level only after it differs for DEBOUNCE_CYCLES straight cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cont   <= '0;
            nivel  <= 1'b0;
            evento <= 1'b0;
        end else begin
            evento <= 1'b0;
            if (pressionado != nivel) begin
                if (cont == CONT_MAX) begin
                    nivel  <= pressionado;
                    cont   <= '0;
                    evento <= pressionado;
                end else begin
                    cont <= cont + CONT_W'(1);
                end
            end else begin
                cont <= '0;
            end
        end
    end

endmodule

// File: rtl/controle_ajuste.sv
// Front-panel adjustment control for the clock counter chain.
// Debounces the three buttons and runs the RUN/AJUSTE mode FSM that
// drives chave_alteracao, seletor and the one-shot incremento.
// Optional auto-repeat of the increment button: define AUTO_REPETICAO_EN.
module controle_ajuste
    import relogio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = 1000000,
    parameter int NUM_DIGITS           = NUM_DIGITS_DEFAULT,
    parameter int BOTAO_ATIVO_BAIXO    = 1,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic                 clk50mhz,
    input  logic                 reset,
    input  logic [3:1]           botao,
    input  logic                 relogio_ativo,
    output logic                 chave_alteracao,
    output logic [SELETOR_W-1:0] seletor,
    output logic                 incremento
);

    // Reject parameter sets the datapath cannot represent
    if (DEBOUNCE_CYCLES < 1 || NUM_DIGITS < 1 || NUM_DIGITS > (1 << SELETOR_W) ||
        REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_param_invalido
        $error("controle_ajuste: invalid parameter set");
    end

    logic [3:1] nivel;
    logic [3:1] evento;

    for (genvar g = 1; g <= 3; g++) begin : g_botao
        debounce_botao #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .BOTAO_ATIVO_BAIXO (BOTAO_ATIVO_BAIXO)
        ) u_debounce (
            .clk    (clk50mhz),
            .rst    (reset),
            .bruto  (botao[g]),
            .nivel  (nivel[g]),
            .evento (evento[g])
        );
    end

    estado_t              estado;
    estado_t              estado_prox;
    logic [SELETOR_W-1:0] seletor_prox;
    logic                 incremento_prox;
    // Set when a digit advance collided with an increment pulse; the advance
    // is applied one cycle later so the pulse is seen with the old digit.
    logic                 avanco_pend;
    logic                 avanco_pend_prox;
    logic                 disparo_repeticao;
    logic                 ev_inc;

`ifdef AUTO_REPETICAO_EN
    logic [31:0] rep_cont;
    logic        rep_armado;
    logic        rep_ativo;

    assign rep_ativo = (estado == AJUSTE) && relogio_ativo && nivel[BOTAO_INC];

    // Repeat fires after the initial delay, then once per period
    always_comb begin
        disparo_repeticao = 1'b0;
        if (rep_ativo) begin
            if (rep_armado) begin
                disparo_repeticao = (rep_cont == 32'(REPEAT_PERIOD_CYCLES));
            end else begin
                disparo_repeticao = (rep_cont == 32'(REPEAT_DELAY_CYCLES));
            end
        end
    end

    // Hold-time counter, cleared on release, mode change or clock disabled
    always_ff @(posedge clk50mhz or posedge reset) begin
        if (reset) begin
            rep_cont   <= '0;
            rep_armado <= 1'b0;
        end else if (!rep_ativo) begin
            rep_cont   <= '0;
            rep_armado <= 1'b0;
        end else if (disparo_repeticao) begin
            rep_cont   <= 32'd1;
            rep_armado <= 1'b1;
        end else begin
            rep_cont <= rep_cont + 32'd1;
        end
    end
`else
    assign disparo_repeticao = 1'b0;
`endif

    // Accepted levels are only consumed by the auto-repeat path
    logic unused_nivel;
    assign unused_nivel = ^nivel;

    assign ev_inc = evento[BOTAO_INC] | disparo_repeticao;

    // FSM state and registered outputs
    always_ff @(posedge clk50mhz or posedge reset) begin
        if (reset) begin
            estado      <= RUN;
            seletor     <= '0;
            incremento  <= 1'b0;
            avanco_pend <= 1'b0;
        end else begin
            estado      <= estado_prox;
            seletor     <= seletor_prox;
            incremento  <= incremento_prox;
            avanco_pend <= avanco_pend_prox;
        end
    end

    // Next state: mode press beats everything; increment uses the current digit
    always_comb begin
        estado_prox      = estado;
        seletor_prox     = seletor;
        incremento_prox  = 1'b0;
        avanco_pend_prox = 1'b0;
        case (estado)
            RUN: begin
                seletor_prox = '0;
                if (evento[BOTAO_MODO]) begin
                    estado_prox = AJUSTE;
                end
            end
            AJUSTE: begin
                if (evento[BOTAO_MODO]) begin
                    estado_prox  = RUN;
                    seletor_prox = '0;
                end else begin
                    incremento_prox = ev_inc && relogio_ativo;
                    if (avanco_pend) begin
                        seletor_prox = proximo_digito(seletor, NUM_DIGITS);
                    end
                    if (evento[BOTAO_PROX]) begin
                        if (ev_inc && relogio_ativo) begin
                            avanco_pend_prox = 1'b1;
                        end else begin
                            seletor_prox = proximo_digito(seletor, NUM_DIGITS);
                        end
                    end
                end
            end
            default: begin
                estado_prox  = RUN;
                seletor_prox = '0;
            end
        endcase
    end

    assign chave_alteracao = (estado == AJUSTE);

endmodule

// File: tb/tb_controle_ajuste.sv
// Bench for controle_ajuste with short debounce/repeat timings.
// Driver issues button presses and queues the expected output events
// (cycle, incremento, chave_alteracao, seletor); a negedge monitor pops
// and compares whenever the outputs pulse or change.
module tb_controle_ajuste;

    localparam int D        = 4;
    localparam int LAT      = 2 + D + 1;
    localparam int R_DELAY  = 10;
    localparam int R_PERIOD = 3;
    localparam int W        = 21;

    logic       clk50mhz = 1'b0;
    logic       reset;
    logic [3:1] botao;
    logic       relogio_ativo;
    logic       chave_alteracao;
    logic [2:0] seletor;
    logic       incremento;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int t0;
    logic [W-1:0] exp_q[$];
    logic [4:0]   last_obs = '0;

    controle_ajuste #(
        .DEBOUNCE_CYCLES      (D),
        .NUM_DIGITS           (6),
        .BOTAO_ATIVO_BAIXO    (1),
        .REPEAT_DELAY_CYCLES  (R_DELAY),
        .REPEAT_PERIOD_CYCLES (R_PERIOD)
    ) dut (
        .clk50mhz        (clk50mhz),
        .reset           (reset),
        .botao           (botao),
        .relogio_ativo   (relogio_ativo),
        .chave_alteracao (chave_alteracao),
        .seletor         (seletor),
        .incremento      (incremento)
    );

    // Clock and cycle counter
    always #5 clk50mhz = ~clk50mhz;
    always @(posedge clk50mhz) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int req);
        tests++;
        if (got != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic push_ev(input int at, input logic inc, input logic chave, input logic [2:0] sel);
        exp_q.push_back({16'(at), inc, chave, sel});
    endtask

    // Press the buttons in mask (active-low raw) right after an edge; t0 = that edge
    task automatic press(input logic [3:1] mask);
        @(posedge clk50mhz);
        #1;
        botao = ~mask;
        t0 = cyc;
    endtask

    task automatic hold_release(input int hold, input int gap);
        repeat (hold) @(posedge clk50mhz);
        #1;
        botao = 3'b111;
        repeat (gap) @(posedge clk50mhz);
    endtask

    // Monitor: every incremento pulse or output change is one event
    always @(negedge clk50mhz) begin
        logic [4:0]   obs;
        logic [W-1:0] e;
        obs = {incremento, chave_alteracao, seletor};
        if (!reset && (incremento || obs[3:0] != last_obs[3:0])) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got cyc=%0d inc=%0b chave=%0b sel=%0d, required no event",
                         cyc, obs[4], obs[3], obs[2:0]);
            end else begin
                e = exp_q.pop_front();
                if (e != {16'(cyc), obs}) begin
                    fails++;
                    $display("FAIL event: got cyc=%0d inc=%0b chave=%0b sel=%0d, required cyc=%0d inc=%0b chave=%0b sel=%0d",
                             cyc, obs[4], obs[3], obs[2:0], e[20:5], e[4], e[3], e[2:0]);
                end
            end
        end
        last_obs = obs;
    end

    initial begin
        int waited;
        botao         = 3'b111;
        relogio_ativo = 1'b1;
        reset         = 1'b1;
        repeat (3) @(posedge clk50mhz);
        #1;
        check("reset_chave", int'(chave_alteracao), 0);
        check("reset_seletor", int'(seletor), 0);
        check("reset_incremento", int'(incremento), 0);
        reset = 1'b0;
        repeat (3) @(posedge clk50mhz);

        // Enter AJUSTE
        press(3'b001);
        push_ev(t0 + LAT, 1'b0, 1'b1, 3'd0);
        hold_release(6, 12);

        // Glitches of 1..3 cycles on increment: nothing expected
        for (int k = 1; k <= 3; k++) begin
            press(3'b010);
            hold_release(k, 10);
        end

        // Long hold: one pulse, LAT cycles after the press
        press(3'b010);
        push_ev(t0 + LAT, 1'b1, 1'b1, 3'd0);
        hold_release(20, 12);

        // Six digit advances: 1,2,3,4,5,0
        for (int k = 1; k <= 6; k++) begin
            press(3'b100);
            push_ev(t0 + LAT, 1'b0, 1'b1, 3'(k % 6));
            hold_release(6, 12);
        end

        // Clock disabled: increment discarded, then enabled: one pulse
        relogio_ativo = 1'b0;
        press(3'b010);
        hold_release(6, 12);
        relogio_ativo = 1'b1;
        press(3'b010);
        push_ev(t0 + LAT, 1'b1, 1'b1, 3'd0);
        hold_release(6, 12);

        // Step to digit 2, then increment+next together
        for (int k = 1; k <= 2; k++) begin
            press(3'b100);
            push_ev(t0 + LAT, 1'b0, 1'b1, 3'(k));
            hold_release(6, 12);
        end
        press(3'b110);
        push_ev(t0 + LAT, 1'b1, 1'b1, 3'd2);
        push_ev(t0 + LAT + 1, 1'b0, 1'b1, 3'd3);
        hold_release(6, 12);

        // Mode+increment together: back to RUN, no pulse
        press(3'b011);
        push_ev(t0 + LAT, 1'b0, 1'b0, 3'd0);
        hold_release(6, 12);

        // In RUN increment and next are ignored
        press(3'b010);
        hold_release(6, 12);
        press(3'b100);
        hold_release(6, 12);

        // Back to AJUSTE, long hold of increment (auto-repeat when enabled)
        press(3'b001);
        push_ev(t0 + LAT, 1'b0, 1'b1, 3'd0);
        hold_release(6, 12);
        press(3'b010);
        push_ev(t0 + LAT, 1'b1, 1'b1, 3'd0);
`ifdef AUTO_REPETICAO_EN
        // Level accepted at edge t0+LAT-1 and dropped at edge t0+36+2+D
        for (int e = t0 + LAT - 1 + R_DELAY; e <= t0 + 36 + 1 + D; e += R_PERIOD) begin
            push_ev(e + 1, 1'b1, 1'b1, 3'd0);
        end
`endif
        hold_release(36, 20);

        // Move to digit 1 so reset has something to clear
        press(3'b100);
        push_ev(t0 + LAT, 1'b0, 1'b1, 3'd1);
        hold_release(6, 12);

        // Reset in the middle of a mode-button debounce, button kept held
        press(3'b001);
        repeat (3) @(posedge clk50mhz);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_chave", int'(chave_alteracao), 0);
        check("async_reset_seletor", int'(seletor), 0);
        check("async_reset_incremento", int'(incremento), 0);
        @(posedge clk50mhz);
        #1;
        reset = 1'b0;
        push_ev(cyc + LAT, 1'b0, 1'b1, 3'd0);
        #1;
        check("post_reset_chave", int'(chave_alteracao), 0);
        check("post_reset_seletor", int'(seletor), 0);
        hold_release(10, 20);

        // All expected events must have been seen
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(posedge clk50mhz);
            waited++;
        end
        check("pending_events", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
